// File: rtl/keypad_pkg.sv
// Shared keypad definitions: emulator state encoding, LFSR taps and the key map
// used by both the emulator and the scanner-side decode.
package keypad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BOUNCE_IN,
    HOLD,
    BOUNCE_OUT,
    GAP
  } emu_state_t;

  // x^8 + x^6 + x^5 + x^4 + 1
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Returns {row[1:0], col[1:0]} for a hex key code
  function automatic logic [3:0] key_to_rc(input logic [3:0] key);
    logic [3:0] rc;
    case (key)
      4'h1: rc = {2'd0, 2'd0};
      4'h2: rc = {2'd0, 2'd1};
      4'h3: rc = {2'd0, 2'd2};
      4'hC: rc = {2'd0, 2'd3};
      4'h4: rc = {2'd1, 2'd0};
      4'h5: rc = {2'd1, 2'd1};
      4'h6: rc = {2'd1, 2'd2};
      4'hD: rc = {2'd1, 2'd3};
      4'h7: rc = {2'd2, 2'd0};
      4'h8: rc = {2'd2, 2'd1};
      4'h9: rc = {2'd2, 2'd2};
      4'hE: rc = {2'd2, 2'd3};
      4'hA: rc = {2'd3, 2'd0};
      4'h0: rc = {2'd3, 2'd1};
      4'hB: rc = {2'd3, 2'd2};
      default: rc = {2'd3, 2'd3};
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/keypad_emulator_lfsr.sv
// 8-bit Fibonacci LFSR that produces the deterministic contact-bounce pattern.
module bounce_lfsr
  import keypad_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [7:0] lfsr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= SEED;
    end else if (en) begin
      lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/keypad_emulator.sv
// 4x4 matrix-keypad emulator: accepts press commands and returns active-high
// columns for the scanned row, with bounce on press and release.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int unsigned BOUNCE_CYCLES = 32,
  parameter int unsigned GAP_CYCLES    = 16,
  parameter int unsigned HOLD_W        = 16,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        keypad_rows,
  output logic [3:0]        keypad_cols,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_key,
  input  logic [HOLD_W-1:0] cmd_hold,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              contact,
  output logic [3:0]        cur_key
);

  localparam int unsigned CNT_W = (HOLD_W > 16) ? HOLD_W : 16;
  localparam logic [CNT_W-1:0] B_LAST = CNT_W'(BOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] G_LAST = CNT_W'(GAP_CYCLES - 1);

  emu_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [HOLD_W-1:0] hold_last_q;
  logic [1:0]        cur_row, cur_col;
  logic [7:0]        lfsr;
  logic              lfsr_en;
  logic              accept;
  logic              done_q;

  assign accept = cmd_valid & (state_q == IDLE);

  bounce_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (lfsr_en),
    .lfsr (lfsr)
  );

  always_comb begin
    state_d = state_q;
    contact = 1'b0;
    lfsr_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) state_d = BOUNCE_IN;
      end
      BOUNCE_IN: begin
        contact = lfsr[0];
        lfsr_en = 1'b1;
        if (abort)                state_d = GAP;
        else if (cnt_q == B_LAST) state_d = HOLD;
      end
      HOLD: begin
        contact = 1'b1;
        if (abort)                             state_d = GAP;
        else if (cnt_q == CNT_W'(hold_last_q)) state_d = BOUNCE_OUT;
      end
      BOUNCE_OUT: begin
        contact = lfsr[0];
        lfsr_en = 1'b1;
        if (abort)                state_d = GAP;
        else if (cnt_q == B_LAST) state_d = GAP;
      end
      GAP: begin
        if (cnt_q == G_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == GAP) && (state_d == IDLE);
      // Idle holds the counter at zero; every transition restarts it
      if (state_d != state_q || state_q == IDLE) cnt_q <= '0;
      else                                      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_key     <= '0;
      cur_row     <= '0;
      cur_col     <= '0;
      hold_last_q <= '0;
    end else if (accept) begin
      cur_key              <= cmd_key;
      {cur_row, cur_col}   <= key_to_rc(cmd_key);
      hold_last_q          <= (cmd_hold == '0) ? '0 : cmd_hold - HOLD_W'(1);
    end
  end

  // Metal contact: no registers between rows and columns
  always_comb begin
    keypad_cols          = '0;
    keypad_cols[cur_col] = contact & keypad_rows[cur_row];
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator: press timing, key map, backpressure,
// abort, asynchronous reset and the minimum-length press.
module tb_keypad_emulator;

  localparam int B = 8;
  localparam int G = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  rows = '0;
  logic [3:0]  cols;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_key = '0;
  logic [15:0] cmd_hold = '0;
  logic        abort = 1'b0;
  logic        busy, done, contact;
  logic [3:0]  cur_key;

  logic [3:0]  s_rows = '0;
  logic [3:0]  s_cols;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [3:0]  s_key = '0;
  logic [15:0] s_hold = '0;
  logic        s_abort = 1'b0;
  logic        s_busy, s_done, s_contact;
  logic [3:0]  s_cur_key;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] lfsr_m = 8'hA5;
  logic [7:0] s_lfsr_m = 8'hA5;

  always #5 clk = ~clk;

  keypad_emulator #(.BOUNCE_CYCLES(B), .GAP_CYCLES(G), .HOLD_W(16), .LFSR_SEED(8'hA5)) u_dut (
    .clk(clk), .rst_n(rst_n), .keypad_rows(rows), .keypad_cols(cols),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_key(cmd_key), .cmd_hold(cmd_hold),
    .abort(abort), .busy(busy), .done(done), .contact(contact), .cur_key(cur_key)
  );

  keypad_emulator #(.BOUNCE_CYCLES(1), .GAP_CYCLES(1), .HOLD_W(16), .LFSR_SEED(8'hA5)) u_dut_small (
    .clk(clk), .rst_n(rst_n), .keypad_rows(s_rows), .keypad_cols(s_cols),
    .cmd_valid(s_valid), .cmd_ready(s_ready), .cmd_key(s_key), .cmd_hold(s_hold),
    .abort(s_abort), .busy(s_busy), .done(s_done), .contact(s_contact), .cur_key(s_cur_key)
  );

  function automatic logic [7:0] step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called at a negedge where cmd_ready is high; returns at the first BOUNCE_IN cycle
  task automatic issue(input logic [3:0] key, input logic [15:0] hold);
    cmd_key   = key;
    cmd_hold  = hold;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("cur_key", cur_key, key);
  endtask

  task automatic bounce_phase(input string tag);
    for (int i = 0; i < B; i++) begin
      chk(tag, contact, lfsr_m[0]);
      chk({tag, "_busy"}, busy, 1'b1);
      chk({tag, "_ready"}, cmd_ready, 1'b0);
      lfsr_m = step(lfsr_m);
      @(negedge clk);
    end
  endtask

  // Runs a press from its first BOUNCE_IN cycle to the done cycle
  task automatic body(input int hold_n, input logic [3:0] erow, input logic [3:0] ecol,
                      input int abort_at);
    logic aborted;
    aborted = 1'b0;
    bounce_phase("bin_contact");
    for (int i = 0; i < hold_n; i++) begin
      rows = 4'b0001 << ((i / 3) % 4);
      #1;
      chk("hold_cols", cols, (rows == erow) ? ecol : 4'b0000);
      chk("hold_contact", contact, 1'b1);
      if (i == 0) begin
        rows = 4'b1111;
        #1;
        chk("multi_row_cols", cols, ecol);
      end
      if (i == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        aborted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!aborted) bounce_phase("bout_contact");
    for (int i = 0; i < G; i++) begin
      abort = (abort_at >= 0) && (i == 1);
      chk("gap_contact", contact, 1'b0);
      chk("gap_busy", busy, 1'b1);
      chk("gap_done", done, 1'b0);
      chk("gap_cols", cols, 4'b0000);
      @(negedge clk);
    end
    abort = 1'b0;
    chk("done_pulse", done, 1'b1);
    chk("done_busy", busy, 1'b0);
    chk("done_ready", cmd_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_contact", contact, 1'b0);
    rows = 4'b1111;
    #1;
    chk("rst_cols", cols, 4'b0000);
    chk("rst_cur_key", cur_key, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Key 5 = row 1, col 1
    issue(4'h5, 16'd10);
    body(10, 4'b0010, 4'b0010, -1);
    @(negedge clk);

    // Key 0 = row 3, col 1
    issue(4'h0, 16'd10);
    body(10, 4'b1000, 4'b0010, -1);

    // Key F = row 3, col 3, with key A queued behind it
    issue(4'hF, 16'd10);
    cmd_key   = 4'hA;
    cmd_hold  = 16'd12;
    cmd_valid = 1'b1;
    body(10, 4'b1000, 4'b1000, -1);
    chk("bp_not_taken", cur_key, 4'hF);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp_cur_key", cur_key, 4'hA);
    chk("bp_busy", busy, 1'b1);
    body(12, 4'b1000, 4'b0001, -1);
    @(negedge clk);

    // Abort in the third hold cycle, then abort asserted with an idle accept
    issue(4'h5, 16'd10);
    body(10, 4'b0010, 4'b0010, 2);
    abort = 1'b1;
    issue(4'h4, 16'd6);
    abort = 1'b0;
    chk("idle_abort_busy", busy, 1'b1);
    body(6, 4'b0010, 4'b0001, -1);
    @(negedge clk);

    // Asynchronous reset during HOLD
    issue(4'h5, 16'd10);
    bounce_phase("rst_bin_contact");
    @(negedge clk);
    @(negedge clk);
    rows = 4'b0010;
    #1;
    chk("pre_rst_cols", cols, 4'b0010);
    rst_n = 1'b0;
    #1;
    chk("async_rst_cols", cols, 4'b0000);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_ready", cmd_ready, 1'b1);
    chk("async_rst_contact", contact, 1'b0);
    chk("async_rst_cur_key", cur_key, 4'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    lfsr_m = 8'hA5;
    issue(4'h5, 16'd10);
    body(10, 4'b0010, 4'b0010, -1);
    @(negedge clk);

    // Minimum press on the B=1, G=1 instance with hold=0
    s_key   = 4'h1;
    s_hold  = 16'd0;
    s_valid = 1'b1;
    s_rows  = 4'b0001;
    @(negedge clk);
    s_valid = 1'b0;
    chk("s_bin_contact", s_contact, s_lfsr_m[0]);
    chk("s_bin_busy", s_busy, 1'b1);
    s_lfsr_m = step(s_lfsr_m);
    @(negedge clk);
    chk("s_hold_contact", s_contact, 1'b1);
    chk("s_hold_cols", s_cols, 4'b0001);
    chk("s_hold_busy", s_busy, 1'b1);
    @(negedge clk);
    chk("s_bout_contact", s_contact, s_lfsr_m[0]);
    chk("s_bout_busy", s_busy, 1'b1);
    @(negedge clk);
    chk("s_gap_contact", s_contact, 1'b0);
    chk("s_gap_busy", s_busy, 1'b1);
    chk("s_gap_done", s_done, 1'b0);
    @(negedge clk);
    chk("s_done", s_done, 1'b1);
    chk("s_done_busy", s_busy, 1'b0);
    @(negedge clk);
    chk("s_done_clear", s_done, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
